// File: rtl/serial_operand_serializer_if.sv
// Operand handshake and serial bit-pair stream between a producer and the serializer.
interface serial_operand_serializer_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned LW = $clog2(W) + 1
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [LW-1:0] in_len;
    logic          hold;
    logic          vld;
    logic          a;
    logic          b;
    logic          last;
    logic          busy;

    modport master (
        output in_valid, in_a, in_b, in_len, hold,
        input  in_ready, vld, a, b, last, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_len, hold,
        output in_ready, vld, a, b, last, busy
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// Streams two parallel operands LSB-first, one bit pair per cycle, with an active
// slot and a pending slot so consecutive operations run back-to-back.
module serial_operand_serializer #(
    parameter int unsigned W  = 8,
    parameter int unsigned LW = $clog2(W) + 1
) (
    input logic                         clk,
    input logic                         rst,
    serial_operand_serializer_if.slave  bus
);

    localparam logic [LW-1:0] WLen = LW'(W);

    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          act_v_q, act_v_d;
    logic [W-1:0]  pa_q, pa_d;
    logic [W-1:0]  pb_q, pb_d;
    logic [LW-1:0] plen_q, plen_d;
    logic          pend_v_q, pend_v_d;

    logic [LW-1:0] eff_len;
    logic          vld;
    logic          last;
    logic          accept;
    logic          free;

    // Zero and out-of-range lengths both request a full-width operation.
    always_comb begin
        eff_len = bus.in_len;
        if (bus.in_len == '0 || bus.in_len > WLen) begin
            eff_len = WLen;
        end
    end

    always_comb begin
        vld          = act_v_q & ~bus.hold;
        last         = vld & (cnt_q == LW'(1));
        bus.vld      = vld;
        bus.last     = last;
        bus.a        = sh_a_q[0] & vld;
        bus.b        = sh_b_q[0] & vld;
        bus.in_ready = ~pend_v_q & ~rst;
        bus.busy     = act_v_q | pend_v_q;
        accept       = bus.in_valid & ~pend_v_q & ~rst;
        free         = ~act_v_q | last;
    end

    always_comb begin
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cnt_d    = cnt_q;
        act_v_d  = act_v_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        plen_d   = plen_q;
        pend_v_d = pend_v_q;

        if (vld && !last) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q - LW'(1);
        end

        if (free) begin
            if (pend_v_q) begin
                sh_a_d   = pa_q;
                sh_b_d   = pb_q;
                cnt_d    = plen_q;
                act_v_d  = 1'b1;
                pend_v_d = 1'b0;
            end else if (accept) begin
                sh_a_d  = bus.in_a;
                sh_b_d  = bus.in_b;
                cnt_d   = eff_len;
                act_v_d = 1'b1;
            end else begin
                act_v_d = 1'b0;
            end
        end else if (accept) begin
            pa_d     = bus.in_a;
            pb_d     = bus.in_b;
            plen_d   = eff_len;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cnt_q    <= '0;
            act_v_q  <= 1'b0;
            pa_q     <= '0;
            pb_q     <= '0;
            plen_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cnt_q    <= cnt_d;
            act_v_q  <= act_v_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            plen_q   <= plen_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
- Upstream feeder for the serial adder: accepts two parallel W-bit operands plus a per-operation length over a valid/ready handshake.
- Streams the operands LSB-first as one bit pair per cycle on a/b, qualified by vld, with last on the final bit of each operation.
- Two-slot buffering (active + pending) so consecutive operations stream back-to-back with no idle cycle.
- A downstream hold input pauses the stream without losing state.

Parameters:
- W, 8, maximum operand width in bits (W >= 1).
- LW, $clog2(W)+1, width of the in_len field.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation this cycle
- in_a  input  W  operand A, bit 0 streamed first
- in_b  input  W  operand B, bit 0 streamed first
- in_len  input  LW  number of bits to stream, 1..W; 0 and values > W both mean W
- hold  input  1  downstream stall; freezes the stream
- vld  output  1  a/b/last valid this cycle
- a  output  1  current bit of A
- b  output  1  current bit of B
- last  output  1  final bit of the current operation (only with vld)
- busy  output  1  active or pending slot occupied

Behaviour:
- Storage:
  - Active slot: sh_a, sh_b shift registers; cnt = remaining bits; act_v.
  - Pending slot: pa, pb, plen; pend_v.
- Outputs (combinational from active slot):
  - vld = act_v & ~hold.
  - a = sh_a[0] & vld; b = sh_b[0] & vld; last = vld & (cnt == 1).
  - When vld = 0, a, b and last are all 0.
- Handshake:
  - in_ready = ~pend_v & ~rst.
  - Accept = in_valid & in_ready. Operand and length are sampled at the accepting edge.
  - in_valid may drop without acceptance; no penalty.
- Definitions:
  - free = ~act_v | (vld & last): the active slot is empty after this edge.
  - Shift: when vld & ~last, shift sh_a and sh_b right by 1 (zero fill) and decrement cnt.
  - Complete: when vld & last, the active slot empties unless it is reloaded in the same edge.
- Load priority at each edge when free:
  1. pend_v: move the pending slot to active; pend_v <= 0. An accept in the same cycle is impossible because in_ready = 0.
  2. Otherwise, if accept: load the input directly to active (bypass).
  3. Otherwise: act_v <= 0.
- If not free and accept: load the pending slot; pend_v <= 1.
- Latency:
  - First bit appears (vld = 1) in the cycle after the accepting edge when the bypass path is taken and hold = 0.
  - Successive operations are gapless: the bit after a last is bit 0 of the next operation in the following cycle.
- Length: cnt loads the effective length (in_len, with 0 or > W mapped to W). len = 1 gives a single cycle with vld = last = 1.
- hold:
  - hold = 1 blocks shifting, completion and active reload.
  - Acceptance into an empty pending slot (or into active if act_v = 0) still proceeds.
  - Holding with act_v = 0 is legal: an operation loads but is not emitted until hold drops.
- Reset (applies mid-operation as well):
  - act_v, pend_v, cnt, shift registers all cleared.
  - vld = a = b = last = 0; in_ready = 0 during rst, 1 in the first cycle after release; busy = 0.
  - A partially streamed operation is discarded and never completes.
- busy = act_v | pend_v.

Test Plan:
- Single op: W=8, in_a=0x5A, in_b=0x3C, in_len=8 accepted at edge 0 -> cycles 1..8 vld=1; a = 0,1,0,1,1,0,1,0; b = 0,0,1,1,1,1,0,0; last only in cycle 8; through serial_adder_with_vld the collected sum is 0x96.
- Back-to-back: offer op1 (0x01, 0x01, len 8) and op2 (0xFF, 0x01, len 4) on consecutive cycles -> op2 is held in pending and in_ready = 0 until op1's last; op2 bit 0 follows op1's last with no gap; 12 vld cycles total with last in cycles 8 and 12.
- Length edges: in_len=1 with in_a=1, in_b=1 -> one cycle with vld = last = a = b = 1. in_len=0 -> 8 bits streamed, same as len 8.
- Hold: assert hold for 3 cycles after bit 2 of 0x5A/0x3C -> vld = a = b = 0 for those 3 cycles; the remaining bits resume unchanged; last is delayed by 3 cycles; no bit is lost or repeated.
- Reset mid-stream: assert rst after bit 4 of an 8-bit op with a pending op queued -> next cycle vld = 0, busy = 0; in_ready = 1 after release; a new op 0x03/0x05 len 3 streams a = 1,1,0 and b = 1,0,1.
- Backpressure: with both slots full, hold in_valid = 1 for 10 cycles -> in_ready stays 0 until the active slot's last; exactly one acceptance per freed pending slot; no operation is duplicated or dropped.
